// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the data memory responder.
// Holds the FSM state encoding, the data word width and the byte-lane count.
// Imported by the responder top and its storage sub-module.
package memory_responder_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/memory_responder_ram.sv
// Word-organised single-port storage with byte-lane write enables and registered read.
// Latency: read data appears one clock after rd_en; writes commit on the enabled edge.
// Backpressure: none, accepts one access per cycle; storage itself is never reset.
module memory_responder_ram
  import memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [BYTE_LANES-1:0] wr_be,
  input  logic [WORD_W-1:0]     wr_data,
  output logic [WORD_W-1:0]     rd_data
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane masked write; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (wr_be[i]) begin
          mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read port, cleared by reset so the output starts known.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-bus responder: latches a request, optionally waits, then pulses mem_ready once.
// Latency: WAIT_CYCLES+1 cycles with DATA_MEMORY_RESPONDER_WAIT_EN defined, otherwise 1.
// Backpressure: initiator holds mem_req until mem_ready; inputs ignored outside IDLE.
module data_memory_responder
  import memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [31:0]           mem_addr,
  input  logic [BYTE_LANES-1:0] mem_be,
  input  logic [WORD_W-1:0]     mem_wdata,
  output logic                  mem_ready,
  output logic [WORD_W-1:0]     mem_rdata,
  output logic                  mem_err
);

  localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t                state, state_nxt;
  logic                  accept;
  logic                  req_oob;
  logic [ADDR_W-1:0]     idx_q;
  logic                  we_q;
  logic                  err_q;
  logic [BYTE_LANES-1:0] be_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [ADDR_W-1:0]     ram_addr;
  logic                  ram_rd_en;
  logic                  ram_wr_en;
  logic [WORD_W-1:0]     ram_rdata;

  // Byte offset bits never select a word.
  logic unused_lsbs;
  assign unused_lsbs = &{1'b0, mem_addr[1:0]};

  assign accept  = (state == IDLE) && mem_req;
  assign req_oob = ({2'b00, mem_addr[31:2]} >= 32'(DEPTH_WORDS));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the request on acceptance; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      idx_q   <= mem_addr[ADDR_W+1:2];
      we_q    <= mem_we;
      err_q   <= req_oob;
      be_q    <= mem_be;
      wdata_q <= mem_wdata;
    end
  end

`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Wait-state down-counter, loaded on acceptance and run while in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end
`else
  // Without wait states the configured count has no effect.
  logic unused_wait_cfg;
  assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

  // Next-state logic: IDLE -> [WAIT] -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_req) begin
`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
          state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
`else
          state_nxt = RESP;
`endif
        end
      end
`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The read is launched on the edge entering RESP and the write commits on the
  // edge leaving it, so the single port is never asked for both at once. In the
  // no-wait build the read launches on the accepting edge, before the latch.
  assign ram_addr  = (state == IDLE) ? mem_addr[ADDR_W+1:2] : idx_q;
  assign ram_rd_en = (state_nxt == RESP);
  assign ram_wr_en = (state == RESP) && we_q && !err_q;

  memory_responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .addr    (ram_addr),
    .rd_en   (ram_rd_en),
    .wr_en   (ram_wr_en),
    .wr_be   (be_q),
    .wr_data (wdata_q),
    .rd_data (ram_rdata)
  );

  // Response outputs are qualified by the RESP state and forced low otherwise.
  assign mem_ready = (state == RESP);
  assign mem_err   = mem_ready && err_q;
  assign mem_rdata = (mem_ready && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with hand-computed expected values.
// Latency expectation follows the DATA_MEMORY_RESPONDER_WAIT_EN build setting.
// Every wait on the DUT is bounded by a cycle budget.
module tb_data_memory_responder;

  localparam int DEPTH = 1024;
  localparam int WAITS = 2;
`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
  localparam int LAT = WAITS + 1;
`else
  localparam int LAT = 1;
`endif
  localparam int PERIOD = LAT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_memory_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction; checks latency and that ready drops after one cycle.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    int cyc;
    bit seen;
    @(negedge clk);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_be    = be;
    mem_wdata = wdata;
    cyc   = 0;
    seen  = 1'b0;
    rdata = '0;
    err   = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_ready) begin
        seen  = 1'b1;
        rdata = mem_rdata;
        err   = mem_err;
      end
      if (cyc == 1) begin
        // Disturb the inputs after acceptance; only latched values may be used.
        mem_addr  = 32'h0000_03FC;
        mem_wdata = ~wdata;
        mem_be    = 4'hF;
        mem_we    = ~we;
      end
    end
    mem_req = 1'b0;
    mem_we  = 1'b0;
    check_eq({tag, "_lat"}, cyc, LAT);
    @(posedge clk);
    #1;
    check_eq({tag, "_rdy_drop"}, {31'b0, mem_ready}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          pulses;
  int          t_pulse [3];
  logic [31:0] d_pulse [3];
  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_exp [3];
  int          n_pulse;
  int          idle_dirty;

  initial begin
    reset     = 1'b1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    #3;
    check_eq("rst_ready", {31'b0, mem_ready}, 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'd0);
    check_eq("rst_err", {31'b0, mem_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Full-word write then read back.
    txn("wr10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er);
    check_eq("wr10_err", {31'b0, er}, 32'd0);
    txn("rd10", 1'b0, 32'h10, 4'h0, 32'h0, rd, er);
    check_eq("rd10_data", rd, 32'hDEADBEEF);
    check_eq("rd10_err", {31'b0, er}, 32'd0);

    // Single byte-lane update.
    txn("pre20", 1'b1, 32'h20, 4'hF, 32'h11223344, rd, er);
    txn("be20", 1'b1, 32'h20, 4'b0010, 32'h0000AA00, rd, er);
    txn("rd20", 1'b0, 32'h20, 4'h0, 32'h0, rd, er);
    check_eq("rd20_data", rd, 32'h1122AA44);
    txn("rd23", 1'b0, 32'h23, 4'h0, 32'h0, rd, er);
    check_eq("rd23_lsb_ignored", rd, 32'h1122AA44);

    // Out-of-range index: error, zero data, no write (index 1024 aliases word 0).
    txn("pre00", 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, rd, er);
    txn("oob_rd", 1'b0, 32'h1000, 4'h0, 32'h0, rd, er);
    check_eq("oob_rd_err", {31'b0, er}, 32'd1);
    check_eq("oob_rd_data", rd, 32'd0);
    txn("oob_wr", 1'b1, 32'h1000, 4'hF, 32'h12345678, rd, er);
    check_eq("oob_wr_err", {31'b0, er}, 32'd1);
    txn("rd00", 1'b0, 32'h0, 4'h0, 32'h0, rd, er);
    check_eq("rd00_data", rd, 32'hCAFEF00D);
    check_eq("rd00_err", {31'b0, er}, 32'd0);

    // Write with no lanes enabled leaves storage unchanged.
    txn("be0", 1'b1, 32'h10, 4'h0, 32'h0, rd, er);
    check_eq("be0_err", {31'b0, er}, 32'd0);
    txn("rd10b", 1'b0, 32'h10, 4'h0, 32'h0, rd, er);
    check_eq("rd10b_data", rd, 32'hDEADBEEF);

    // Reset right after acceptance aborts the write; storage survives.
    txn("pre30", 1'b1, 32'h30, 4'hF, 32'h5, rd, er);
    @(negedge clk);
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h30;
    mem_be    = 4'hF;
    mem_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    mem_we  = 1'b0;
`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
    check_eq("abort_wait_ready", {31'b0, mem_ready}, 32'd0);
`endif
    reset = 1'b1;
    #1;
    check_eq("abort_async_ready", {31'b0, mem_ready}, 32'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      pulses += int'(mem_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      pulses += int'(mem_ready);
    end
    check_eq("abort_no_pulse", pulses, 32'd0);
    txn("rd30", 1'b0, 32'h30, 4'h0, 32'h0, rd, er);
    check_eq("rd30_data", rd, 32'h5);

    // Back-to-back reads with mem_req held high.
    b2b_addr[0] = 32'h10;       b2b_exp[0] = 32'hDEADBEEF;
    b2b_addr[1] = 32'h20;       b2b_exp[1] = 32'h1122AA44;
    b2b_addr[2] = 32'h30;       b2b_exp[2] = 32'h5;
    n_pulse    = 0;
    idle_dirty = 0;
    @(negedge clk);
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = b2b_addr[0];
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        if (n_pulse < 3) begin
          t_pulse[n_pulse] = i;
          d_pulse[n_pulse] = mem_rdata;
        end
        n_pulse++;
        if (n_pulse < 3) mem_addr = b2b_addr[n_pulse];
        else mem_req = 1'b0;
      end else if (mem_rdata != 32'd0 || mem_err) begin
        idle_dirty++;
      end
    end
    mem_req = 1'b0;
    check_eq("b2b_count", n_pulse, 32'd3);
    if (n_pulse >= 3) begin
      check_eq("b2b_first", t_pulse[0], LAT);
      check_eq("b2b_gap1", t_pulse[1] - t_pulse[0], PERIOD);
      check_eq("b2b_gap2", t_pulse[2] - t_pulse[1], PERIOD);
      for (int k = 0; k < 3; k++) begin
        check_eq($sformatf("b2b_data%0d", k), d_pulse[k], b2b_exp[k]);
      end
    end
    check_eq("b2b_quiet_outputs", idle_dirty, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
